// File: rtl/mem_burst_master.sv
// Burst command sequencer for a single-port WIDTH x DEPTH memory: splits one read/write
// burst into single-beat memory transactions paced on the memory's registered ready.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   FETCH | write only: waiting for the next write-data word
//   ISSUE | one-cycle m_valid for the current beat
//   WAIT  | waiting for m_ready, timeout running
//   DONE  | one-cycle done pulse
//   ERR   | one-cycle err pulse (bad length or timeout)
module mem_burst_master #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = $clog2(MAX_LEN + 1),
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  res_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]      cmd_len_i,
  input  logic                  wd_valid_i,
  output logic                  wd_ready_o,
  input  logic [WIDTH-1:0]      wd_data_i,
  output logic                  rd_valid_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  m_valid_o,
  output logic                  m_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [WIDTH-1:0]      m_wdata_o,
  input  logic [WIDTH-1:0]      m_rdata_i,
  input  logic                  m_ready_i
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  rd_valid_q, rd_valid_d;

  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          wr_d   = cmd_wr_i;
          addr_d = cmd_addr_i;
          len_d  = cmd_len_i;
          cnt_d  = '0;
          if (cmd_len_i == '0 || cmd_len_i > LEN_W'(MAX_LEN)) begin
            state_d = S_ERR;
          end else begin
            state_d = cmd_wr_i ? S_FETCH : S_ISSUE;
          end
        end
      end
      S_FETCH: begin
        if (wd_valid_i) begin
          wdata_d = wd_data_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = TMO_W'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_ready_i) begin
          if (!wr_q) begin
            rdata_d    = m_rdata_i;
            rd_valid_d = 1'b1;
          end
          cnt_d  = cnt_q + LEN_W'(1);
          // DEPTH is a power of two, so the increment wraps to 0 by itself
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (cnt_q + LEN_W'(1) == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = wr_q ? S_FETCH : S_ISSUE;
          end
        end else if (tmo_q == '0) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state_q == S_IDLE);
    wd_ready_o  = (state_q == S_FETCH);
    m_valid_o   = (state_q == S_ISSUE);
    done_o      = (state_q == S_DONE);
    err_o       = (state_q == S_ERR);
    m_wr_rd_o   = wr_q;
    m_addr_o    = addr_q;
    m_wdata_o   = wdata_q;
    rd_valid_o  = rd_valid_q;
    rd_data_o   = rdata_q;
  end

endmodule
